// File: rtl/ch376_pkg.sv
// Shared constants and encodings for the CH376 parallel-bus controller.
package ch376_pkg;

  localparam logic [7:0] CMD_GET_STATUS = 8'h22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  typedef enum logic [1:0] {
    OWN_CPU,
    OWN_POLL_CMD,
    OWN_POLL_RD
  } owner_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ch376_int_sync.sv
// Two-flop synchronizer for CH376 INT# plus a one-cycle falling-edge pulse.
module ch376_int_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_int_n,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_int_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/ch376_bus_ctrl.sv
// CH376 bus sequencer: arbitrates CPU accesses against an INT#-driven GET_STATUS poll.
module ch376_bus_ctrl
  import ch376_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int RECOVER_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic [7:0] status,
  output logic       status_valid,
  input  logic       status_clr,
  input  logic       ch_int_n,
  output logic       ch_cs_n,
  output logic       ch_rd_n,
  output logic       ch_wr_n,
  output logic       ch_a0,
  output logic [7:0] ch_dout,
  output logic       ch_oe,
  input  logic [7:0] ch_din
);

  localparam int CNT_MAX = max3(SETUP_CYC, STROBE_CYC, RECOVER_CYC);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t        r_state, w_state_nxt;
  owner_t        r_own, w_own_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_wr, w_wr_nxt, r_a0, w_a0_nxt;
  logic [7:0]    r_dout, w_dout_nxt;
  logic          w_grant_cpu, w_grant_poll, w_poll_done, w_sample, w_on_bus, w_fall;
  logic          r_cs_n, r_rd_n, r_wr_n, r_oe, r_ack;
  logic [7:0]    r_cpu_rdata, r_rdbuf, r_status;
  logic          r_status_valid, r_int_pend, r_int_prio;

  ch376_int_sync u_int_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_int_n (ch_int_n),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_own   <= OWN_CPU;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_own_nxt    = r_own;
    w_cnt_nxt    = r_cnt;
    w_wr_nxt     = r_wr;
    w_a0_nxt     = r_a0;
    w_dout_nxt   = r_dout;
    w_grant_cpu  = 1'b0;
    w_grant_poll = 1'b0;
    w_poll_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The interrupt jumps the queue once it has already waited through a CPU grant.
        if (r_int_pend && (r_int_prio || !cpu_req)) begin
          w_grant_poll = 1'b1;
          w_state_nxt  = ST_SETUP;
          w_own_nxt    = OWN_POLL_CMD;
          w_cnt_nxt    = CW'(SETUP_CYC - 1);
          w_wr_nxt     = 1'b1;
          w_a0_nxt     = 1'b1;
          w_dout_nxt   = CMD_GET_STATUS;
        end else if (cpu_req) begin
          w_grant_cpu  = 1'b1;
          w_state_nxt  = ST_SETUP;
          w_own_nxt    = OWN_CPU;
          w_cnt_nxt    = CW'(SETUP_CYC - 1);
          w_wr_nxt     = cpu_wr;
          w_a0_nxt     = cpu_a0;
          w_dout_nxt   = cpu_wdata;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = CW'(STROBE_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) w_state_nxt = ST_HOLD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_HOLD: begin
        w_state_nxt = ST_RECOVER;
        w_cnt_nxt   = CW'(RECOVER_CYC - 1);
      end
      ST_RECOVER: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (r_own == OWN_POLL_CMD) begin
          // Chain straight into the status read so the CPU cannot slip in between.
          w_state_nxt = ST_SETUP;
          w_own_nxt   = OWN_POLL_RD;
          w_cnt_nxt   = CW'(SETUP_CYC - 1);
          w_wr_nxt    = 1'b0;
          w_a0_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_poll_done = (r_own == OWN_POLL_RD);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_on_bus = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                    (w_state_nxt == ST_HOLD);
  assign w_sample = (r_state == ST_STROBE) && (r_cnt == '0) && !r_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr           <= 1'b0;
      r_a0           <= 1'b0;
      r_dout         <= 8'h00;
      r_cs_n         <= 1'b1;
      r_rd_n         <= 1'b1;
      r_wr_n         <= 1'b1;
      r_oe           <= 1'b0;
      r_ack          <= 1'b0;
      r_cpu_rdata    <= 8'h00;
      r_rdbuf        <= 8'h00;
      r_status       <= 8'h00;
      r_status_valid <= 1'b0;
      r_int_pend     <= 1'b0;
      r_int_prio     <= 1'b0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_a0   <= w_a0_nxt;
      r_dout <= w_dout_nxt;
      r_cs_n <= ~w_on_bus;
      r_wr_n <= ~((w_state_nxt == ST_STROBE) && w_wr_nxt);
      r_rd_n <= ~((w_state_nxt == ST_STROBE) && !w_wr_nxt);
      r_oe   <= w_on_bus && w_wr_nxt;
      r_ack  <= (w_state_nxt == ST_HOLD) && (w_own_nxt == OWN_CPU);
      if (w_sample) begin
        if (r_own == OWN_CPU) r_cpu_rdata <= ch_din;
        else                  r_rdbuf     <= ch_din;
      end
      r_int_pend <= w_fall | (r_int_pend & ~w_grant_poll);
      if (w_grant_poll)     r_int_prio <= 1'b0;
      else if (w_grant_cpu) r_int_prio <= r_int_pend;
      if (w_poll_done) r_status <= r_rdbuf;
      if (w_poll_done)     r_status_valid <= 1'b1;
      else if (status_clr) r_status_valid <= 1'b0;
    end
  end

  assign ch_cs_n      = r_cs_n;
  assign ch_rd_n      = r_rd_n;
  assign ch_wr_n      = r_wr_n;
  assign ch_oe        = r_oe;
  assign ch_a0        = r_a0;
  assign ch_dout      = r_dout;
  assign cpu_ack      = r_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign status       = r_status;
  assign status_valid = r_status_valid;

endmodule

// File: tb/tb_ch376_bus_ctrl.sv
// Scoreboard bench for ch376_bus_ctrl: bus cycles and CPU acks are checked by monitors.
module tb_ch376_bus_ctrl;

  typedef struct packed {
    logic       a0;
    logic       wr;
    logic [7:0] data;
  } bus_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_wr = 1'b0, cpu_a0 = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_ack;
  logic [7:0] cpu_rdata, status;
  logic       status_valid;
  logic       status_clr = 1'b0;
  logic       ch_int_n = 1'b1;
  logic       ch_cs_n, ch_rd_n, ch_wr_n, ch_a0, ch_oe;
  logic [7:0] ch_dout;
  logic [7:0] ch_din = 8'h00;

  int         total = 0, bad = 0;
  bus_t       exp_bus[$];
  logic [7:0] exp_ack[$];
  logic [7:0] m_rdata = 8'h00;

  ch376_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .status(status), .status_valid(status_valid), .status_clr(status_clr),
    .ch_int_n(ch_int_n), .ch_cs_n(ch_cs_n), .ch_rd_n(ch_rd_n), .ch_wr_n(ch_wr_n),
    .ch_a0(ch_a0), .ch_dout(ch_dout), .ch_oe(ch_oe), .ch_din(ch_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  function automatic bus_t mk(input logic a0, input logic wr, input logic [7:0] d);
    bus_t b;
    b.a0 = a0; b.wr = wr; b.data = d;
    return b;
  endfunction

  // Bus monitor: one scoreboard pop per bus cycle, at the first strobe cycle.
  logic m_in = 1'b0, m_seen = 1'b0;
  int   m_slen = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      m_in = 1'b0;
      m_seen = 1'b0;
    end else begin
      if (!ch_cs_n && !m_in) begin
        m_in = 1'b1; m_seen = 1'b0; m_slen = 0;
      end
      if (m_in && (!ch_wr_n || !ch_rd_n)) begin
        if (!m_seen) begin
          bus_t e;
          m_seen = 1'b1;
          if (exp_bus.size() == 0) flag("bus_unexpected_cycle");
          else begin
            e = exp_bus.pop_front();
            chk("bus_a0", ch_a0, e.a0);
            chk("bus_dir_wr", !ch_wr_n, e.wr);
            if (e.wr) chk("bus_wdata", ch_dout, e.data);
          end
        end
        chk("bus_oe", ch_oe, !ch_wr_n);
        m_slen++;
      end
      if (m_in && ch_cs_n) begin
        m_in = 1'b0;
        if (m_seen) chk("strobe_len", m_slen, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && cpu_ack) begin
      if (exp_ack.size() == 0) flag("ack_unexpected");
      else chk("ack_rdata", cpu_rdata, exp_ack.pop_front());
    end
  end

  task automatic cpu_op(input logic wr, input logic a0, input logic [7:0] wd);
    int n;
    exp_bus.push_back(mk(a0, wr, wd));
    if (!wr) m_rdata = ch_din;
    exp_ack.push_back(m_rdata);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_a0 = a0; cpu_wdata = wd;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cpu_ack) break;
    end
    cpu_req = 1'b0;
    if (n == 50) flag("cpu_op_timeout");
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_idle(input int cyc);
    repeat (cyc) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v_cs, v_wr, v_ack, v_oe;
    int first_cs, n, acks;
    logic seen_rd;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {ch_cs_n, ch_rd_n, ch_wr_n, ch_oe, ch_a0}, 5'b11100);
    chk("rst_dout", ch_dout, 8'h00);
    chk("rst_cpu", {cpu_ack, cpu_rdata}, 9'h000);
    chk("rst_status", {status_valid, status}, 9'h000);

    // CPU command write 06h: cycle-by-cycle waveform, bit i = cycle k+1+i
    exp_bus.push_back(mk(1'b1, 1'b1, 8'h06));
    exp_ack.push_back(m_rdata);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_wdata = 8'h06;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v_cs[i] = ch_cs_n; v_wr[i] = ch_wr_n; v_ack[i] = cpu_ack; v_oe[i] = ch_oe;
      if (cpu_ack) cpu_req = 1'b0;
    end
    chk("w06_cs_n", v_cs, 8'b1110_0000);
    chk("w06_wr_n", v_wr, 8'b1111_0001);
    chk("w06_ack", v_ack, 8'b0001_0000);
    chk("w06_oe", v_oe, 8'b0001_1111);
    wait_idle(2);

    // CPU data read 51h, then a write must leave cpu_rdata held
    ch_din = 8'h51;
    cpu_op(1'b0, 1'b0, 8'h00);
    ch_din = 8'h00;
    cpu_op(1'b1, 1'b0, 8'h5A);
    chk("rdata_held", cpu_rdata, 8'h51);

    // INT# pulse: poll reads 14h
    ch_din = 8'h14;
    exp_bus.push_back(mk(1'b1, 1'b1, 8'h22));
    exp_bus.push_back(mk(1'b0, 1'b0, 8'h00));
    @(posedge clk); #1 ch_int_n = 1'b0;
    first_cs = 0;
    for (n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 4) ch_int_n = 1'b1;
      if (!ch_cs_n && first_cs == 0) first_cs = n;
      if (status_valid) break;
    end
    chk("int_to_cs", first_cs, 4);
    chk("int_to_valid", n, 18);
    chk("poll_status", status, 8'h14);
    @(posedge clk); #1 status_clr = 1'b1;
    @(posedge clk); #1 status_clr = 1'b0;
    @(negedge clk);
    chk("clr_valid", status_valid, 1'b0);
    wait_idle(4);

    // CPU request held while INT# falls: CPU, poll cmd, poll read, CPU
    ch_din = 8'h77;
    exp_bus.push_back(mk(1'b0, 1'b1, 8'hA5));
    exp_bus.push_back(mk(1'b1, 1'b1, 8'h22));
    exp_bus.push_back(mk(1'b0, 1'b0, 8'h00));
    exp_bus.push_back(mk(1'b0, 1'b1, 8'h3C));
    exp_ack.push_back(m_rdata);
    exp_ack.push_back(m_rdata);
    @(posedge clk); #1 ch_int_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a0 = 1'b0; cpu_wdata = 8'hA5; ch_int_n = 1'b1;
    acks = 0;
    for (n = 0; n < 100 && acks < 2; n++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acks++;
        if (acks == 1) cpu_wdata = 8'h3C;
        else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("rr_acks", acks, 2);
    chk("rr_bus_left", exp_bus.size(), 0);
    chk("rr_status", {status_valid, status}, 9'h177);
    @(posedge clk); #1 status_clr = 1'b1;
    @(posedge clk); #1 status_clr = 1'b0;
    wait_idle(4);

    // Second INT# edge during a poll, status_clr in the completion cycle
    ch_din = 8'h41;
    for (int i = 0; i < 2; i++) begin
      exp_bus.push_back(mk(1'b1, 1'b1, 8'h22));
      exp_bus.push_back(mk(1'b0, 1'b0, 8'h00));
    end
    @(posedge clk); #1 ch_int_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 ch_int_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 ch_int_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 ch_int_n = 1'b1;
    seen_rd = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!ch_rd_n) seen_rd = 1'b1;
      if (seen_rd && ch_rd_n && !ch_cs_n) break;
    end
    chk("dbl_hold_found", n < 60, 1'b1);
    ch_din = 8'h3C;
    @(posedge clk);
    @(posedge clk); #1 status_clr = 1'b1;
    @(posedge clk); #1 status_clr = 1'b0;
    @(negedge clk);
    chk("clr_vs_set_valid", status_valid, 1'b1);
    chk("dbl_first_status", status, 8'h41);
    wait_idle(40);
    chk("dbl_bus_left", exp_bus.size(), 0);
    chk("dbl_second_status", {status_valid, status}, 9'h13C);

    // Reset asserted during the strobe of a CPU write
    exp_bus.push_back(mk(1'b1, 1'b1, 8'h99));
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_wdata = 8'h99;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!ch_wr_n) break;
    end
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_pins", {ch_wr_n, ch_cs_n, ch_oe}, 3'b110);
    cpu_req = 1'b0;
    m_rdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst2_strobes", {ch_cs_n, ch_rd_n, ch_wr_n, ch_oe, ch_a0}, 5'b11100);
    chk("rst2_cpu", {cpu_ack, cpu_rdata}, 9'h000);
    chk("rst2_status", {status_valid, status}, 9'h000);
    wait_idle(10);
    chk("rst2_no_bus", ch_cs_n, 1'b1);
    chk("end_bus_queue", exp_bus.size(), 0);
    chk("end_ack_queue", exp_ack.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch376_bus_ctrl.md
# ch376_bus_ctrl

Sequences all accesses to the CH376S parallel bus (CS#, RD#, WR#, A0, D[7:0]) on the cartridge side. Arbitrates between MSX CPU I/O requests, decoded upstream from port 10h/11h, and an autonomous interrupt engine. On each CH376 INT# falling edge, the engine issues GET_STATUS (22h) and latches the result for the CPU. Sits between the I/O decoder and the CH376 pins, replacing the direct CS/BUSDIR glue.

## Interface
Parameters:
- SETUP_CYC, 1, cycles with CS#/A0/write data valid before the strobe asserts (≥1)
- STROBE_CYC, 3, cycles RD# or WR# is held low (≥1)
- RECOVER_CYC, 2, cycles CS# is high between consecutive bus cycles (≥1)

Ports:
- clk  in  1  system clock; the single clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_a0  in  1  1 = command port, 0 = data port
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid with cpu_ack, held until the next CPU read
- status  out  8  last GET_STATUS result
- status_valid  out  1  status holds an unread result
- status_clr  in  1  one-cycle pulse that clears status_valid
- ch_int_n  in  1  CH376 INT#, asynchronous
- ch_cs_n, ch_rd_n, ch_wr_n  out  1 each  CH376 strobes, active low
- ch_a0  out  1  CH376 A0
- ch_dout  out  8  data toward CH376
- ch_oe  out  1  drive enable for ch_dout
- ch_din  in  8  data from CH376

## Operation
- Bus cycle FSM states and order: IDLE → SETUP (SETUP_CYC) → STROBE (STROBE_CYC) → HOLD (1) → RECOVER (RECOVER_CYC) → IDLE.
- CS# is low in SETUP, STROBE and HOLD.
- RD# or WR# is low only in STROBE.
- ch_oe is high in SETUP, STROBE and HOLD of write cycles only.
- Reads sample ch_din on the last STROBE cycle.
- Interrupt detection: ch_int_n passes a 2-FF synchronizer. A high→low transition of the synchronized signal sets int_pend.
- A poll is two atomic bus cycles: a command write of 22h with A0=1, then a data read with A0=0.
  - The CPU cannot interleave between the two cycles.
  - int_pend clears when the poll starts.
- Poll completion loads status from the read data and sets status_valid.
- Arbitration in IDLE: a pending cpu_req wins over int_pend. Exception: int_pend is served first if the previous granted cycle was a CPU cycle and int_pend was already set at that grant. This is round-robin fairness; the interrupt waits at most one CPU cycle.
- Polls run regardless of status_valid. A new result overwrites status; status_valid stays 1.
- If status_clr and poll completion occur in the same cycle, set wins: status_valid = 1.
- A falling edge arriving during a poll sets int_pend again and is served afterwards.
- Reset values:
  - ch_cs_n/ch_rd_n/ch_wr_n = 1; ch_oe = 0; ch_a0 = 0; ch_dout = 00h.
  - cpu_ack = 0; cpu_rdata = 00h; status = 00h; status_valid = 0; int_pend = 0.
  - Synchronizer flops = 1; FSM = IDLE.
- Reset asserted mid-cycle forces strobes high and ch_oe low asynchronously. Any in-flight access is abandoned with no ack.

## Timing
- cpu_req sampled in IDLE at edge k → SETUP from k+1.
- cpu_ack and cpu_rdata at cycle k+SETUP_CYC+STROBE_CYC+1 (HOLD). Defaults: k+5.
- Next grant sampled in IDLE no earlier than k+SETUP_CYC+STROBE_CYC+RECOVER_CYC+2. Defaults: k+8.
- Outputs are registered; no combinational path from cpu_* to ch_*.
- INT# falling edge to int_pend: 3 clocks.
- Poll from IDLE grant to status_valid: 2·(SETUP+STROBE+1+RECOVER) cycles. Defaults: 14.

## Structure
- Package ch376_pkg:
  - CMD_GET_STATUS = 8'h22.
  - FSM state encoding: IDLE, SETUP, STROBE, HOLD, RECOVER.
  - Owner encoding: CPU, POLL_CMD, POLL_RD.
- Sub-module ch376_int_sync: 2-FF synchronizer plus falling-edge pulse, reset to 1.
- A phase counter sized for max(SETUP_CYC, STROBE_CYC, RECOVER_CYC) is shared across states.

## Test plan
- CPU write: cmd 06h, A0=1.
  - CS# low cycles k+1..k+5; WR# low k+2..k+4; ch_dout = 06h with ch_oe = 1.
  - cpu_ack at k+5; CS# high k+6..k+7.
- CPU read: A0=0 with ch_din = 51h → RD# low for 3 cycles, ch_oe = 0, cpu_rdata = 51h with cpu_ack, value held afterwards.
- INT# pulse low, ch_din = 14h:
  - write 22h with A0=1, then read with A0=0.
  - status = 14h, status_valid = 1; status_clr → 0.
- cpu_req held continuously while INT# falls → CPU cycle, then a complete poll, then CPU again. No CPU access between the poll's write and read.
- status_clr in the poll-completion cycle → status_valid = 1. A second INT# edge during a poll triggers exactly one further poll.
- reset_n low during STROBE of a write → ch_wr_n = 1 and ch_oe = 0 immediately, no cpu_ack. After release, IDLE with all reset values.
